// File: rtl/rv32_decode_stage_pkg.sv
// Shared RV32 defines: opcodes, ALU op / operand-select codes, immediate
// types and the packed decode record registered by the decode stage.
// No ports; imported by rv32_decode_stage, rv32_imm_gen and the ALU.
package rv32_decode_stage_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;

  // ALU op codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_XOR   = 4'b0001;
  localparam logic [3:0] ALU_OR    = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_FXMUL = 4'b1000;

  // ALU operand selects
  localparam logic [1:0] SRC1_REG  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZERO = 2'b10;
  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_FOUR = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Everything the stage registers except the PC.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_write;
    logic [3:0]  alu_op;
    logic        alu_sub_sra;
    logic [1:0]  alu_src1;
    logic [1:0]  alu_src2;
    logic [31:0] imm;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_width;
    logic        mem_zero_ext;
    logic        branch;
    logic [2:0]  branch_op;
    logic        jump;
    logic        jump_reg;
    logic        illegal;
  } dec_t;

  // OP / OP-IMM funct3 to ALU op.
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Turn a record into a bubble: data fields are kept, every control that
  // could cause a later-stage side effect is cleared.
  function automatic dec_t kill_side_effects(input dec_t d);
    dec_t r;
    r           = d;
    r.valid     = 1'b0;
    r.rd_write  = 1'b0;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    r.branch    = 1'b0;
    r.jump      = 1'b0;
    r.jump_reg  = 1'b0;
    r.illegal   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/rv32_decode_stage_imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of instr.
// Latency: combinational. Backpressure: none (pure function).
// Ports: instr (32b word), imm_type (IMM_* code), imm (32b immediate).
module rv32_imm_gen
  import rv32_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  imm_type,
  output logic [31:0] imm
);

  // The opcode bits never contribute to an immediate.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I (+FXMUL) decode stage feeding the ALU.
// Latency: 1 cycle from instr_in/pc_in to the *_out registers.
// Backpressure: stall_in holds every register; flush_in turns the held entry into a bubble.
// Ports: clk/reset (sync, active high); valid_in, instr_in, pc_in, stall_in, flush_in in;
//        valid_out, pc_out, register indices, ALU controls, immediate, memory,
//        branch/jump controls and illegal_out out.
module rv32_decode_stage
  import rv32_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [3:0]  alu_op_out,
  output logic        alu_sub_sra_out,
  output logic [1:0]  alu_src1_out,
  output logic [1:0]  alu_src2_out,
  output logic [31:0] imm_value_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [1:0]  mem_width_out,
  output logic        mem_zero_ext_out,
  output logic        branch_out,
  output logic [2:0]  branch_op_out,
  output logic        jump_out,
  output logic        jump_reg_out,
  output logic        illegal_out
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [2:0]  imm_type;
  logic [31:0] imm_value;
  logic        wr_en;
  logic        illegal;
  dec_t        dec_c;
  dec_t        dec_next;
  dec_t        dec_q;
  logic [31:0] pc_q;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];

  rv32_imm_gen u_imm_gen (
    .instr    (instr_in),
    .imm_type (imm_type),
    .imm      (imm_value)
  );

  always_comb begin
    dec_c          = '0;
    dec_c.valid    = 1'b1;
    dec_c.rs1      = instr_in[19:15];
    dec_c.rs2      = instr_in[24:20];
    dec_c.rd       = instr_in[11:7];
    dec_c.alu_op   = ALU_ADD;
    dec_c.alu_src1 = SRC1_REG;
    dec_c.alu_src2 = SRC2_REG;
    imm_type       = IMM_I;
    wr_en          = 1'b0;
    illegal        = 1'b0;

    if (instr_in[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec_c.alu_src1 = SRC1_ZERO;
          dec_c.alu_src2 = SRC2_IMM;
          imm_type       = IMM_U;
          wr_en          = 1'b1;
        end
        OPC_AUIPC: begin
          dec_c.alu_src1 = SRC1_PC;
          dec_c.alu_src2 = SRC2_IMM;
          imm_type       = IMM_U;
          wr_en          = 1'b1;
        end
        OPC_JAL: begin
          // ALU produces the link value pc+4; the target uses the immediate.
          dec_c.alu_src1 = SRC1_PC;
          dec_c.alu_src2 = SRC2_FOUR;
          imm_type       = IMM_J;
          wr_en          = 1'b1;
          dec_c.jump     = 1'b1;
        end
        OPC_JALR: begin
          dec_c.alu_src1 = SRC1_PC;
          dec_c.alu_src2 = SRC2_FOUR;
          imm_type       = IMM_I;
          wr_en          = 1'b1;
          dec_c.jump     = 1'b1;
          dec_c.jump_reg = 1'b1;
          if (funct3 != 3'b000) illegal = 1'b1;
        end
        OPC_BRANCH: begin
          // Comparison is done by subtracting; funct3[2:1] picks eq/lt/ltu.
          imm_type          = IMM_B;
          dec_c.alu_sub_sra = 1'b1;
          dec_c.branch      = 1'b1;
          dec_c.branch_op   = funct3;
          case (funct3[2:1])
            2'b00:   dec_c.alu_op = ALU_ADD;
            2'b10:   dec_c.alu_op = ALU_SLT;
            2'b11:   dec_c.alu_op = ALU_SLTU;
            default: illegal = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec_c.alu_src2     = SRC2_IMM;
          imm_type           = IMM_I;
          wr_en              = 1'b1;
          dec_c.mem_read     = 1'b1;
          dec_c.mem_width    = funct3[1:0];
          dec_c.mem_zero_ext = funct3[2];
          if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
        end
        OPC_STORE: begin
          dec_c.alu_src2  = SRC2_IMM;
          imm_type        = IMM_S;
          dec_c.mem_write = 1'b1;
          dec_c.mem_width = funct3[1:0];
          if (funct3 >= 3'b011) illegal = 1'b1;
        end
        OPC_OP_IMM: begin
          dec_c.alu_op   = alu_op_from_funct3(funct3);
          dec_c.alu_src2 = SRC2_IMM;
          imm_type       = IMM_I;
          wr_en          = 1'b1;
          case (funct3)
            3'b001: if (funct7 != 7'b0000000) illegal = 1'b1;
            3'b101: begin
              if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
              dec_c.alu_sub_sra = instr_in[30];
            end
            // SLTI/SLTIU read the subtractor's flags.
            3'b010, 3'b011: dec_c.alu_sub_sra = 1'b1;
            default: ;
          endcase
        end
        OPC_OP: begin
          dec_c.alu_op = alu_op_from_funct3(funct3);
          wr_en        = 1'b1;
          if (funct7 == 7'b0100000) begin
            if (funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
          end else if (funct7 != 7'b0000000) begin
            illegal = 1'b1;
          end
          case (funct3)
            3'b000, 3'b101: dec_c.alu_sub_sra = instr_in[30];
            3'b010, 3'b011: dec_c.alu_sub_sra = 1'b1;
            default: ;
          endcase
        end
        OPC_CUSTOM0: begin
          dec_c.alu_op = ALU_FXMUL;
          wr_en        = 1'b1;
          if (funct3 != 3'b000 || funct7 != 7'b0000000) illegal = 1'b1;
        end
        OPC_MISC_MEM: begin
          // FENCE: a live no-op with no writeback.
        end
        default: illegal = 1'b1;
      endcase
    end

    if (illegal) begin
      dec_c.mem_read  = 1'b0;
      dec_c.mem_write = 1'b0;
      dec_c.branch    = 1'b0;
      dec_c.jump      = 1'b0;
      dec_c.jump_reg  = 1'b0;
      dec_c.illegal   = 1'b1;
    end
    dec_c.rd_write = wr_en & ~illegal & (dec_c.rd != 5'd0);
  end

  always_comb begin
    dec_next     = dec_c;
    dec_next.imm = imm_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q <= '0;
      pc_q  <= RESET_PC;
    end else if (flush_in) begin
      dec_q <= kill_side_effects(dec_q);
    end else if (!stall_in) begin
      pc_q  <= pc_in;
      dec_q <= valid_in ? dec_next : kill_side_effects(dec_next);
    end
  end

  assign valid_out        = dec_q.valid;
  assign pc_out           = pc_q;
  assign rs1_out          = dec_q.rs1;
  assign rs2_out          = dec_q.rs2;
  assign rd_out           = dec_q.rd;
  assign rd_write_out     = dec_q.rd_write;
  assign alu_op_out       = dec_q.alu_op;
  assign alu_sub_sra_out  = dec_q.alu_sub_sra;
  assign alu_src1_out     = dec_q.alu_src1;
  assign alu_src2_out     = dec_q.alu_src2;
  assign imm_value_out    = dec_q.imm;
  assign mem_read_out     = dec_q.mem_read;
  assign mem_write_out    = dec_q.mem_write;
  assign mem_width_out    = dec_q.mem_width;
  assign mem_zero_ext_out = dec_q.mem_zero_ext;
  assign branch_out       = dec_q.branch;
  assign branch_op_out    = dec_q.branch_op;
  assign jump_out         = dec_q.jump;
  assign jump_reg_out     = dec_q.jump_reg;
  assign illegal_out      = dec_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
module tb_rv32_decode_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, valid_in, stall_in, flush_in;
  logic [31:0] instr_in, pc_in;
  logic        valid_out, rd_write_out, alu_sub_sra_out;
  logic [31:0] pc_out, imm_value_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [3:0]  alu_op_out;
  logic [1:0]  alu_src1_out, alu_src2_out, mem_width_out;
  logic        mem_read_out, mem_write_out, mem_zero_ext_out;
  logic        branch_out, jump_out, jump_reg_out, illegal_out;
  logic [2:0]  branch_op_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_decode_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .stall_in(stall_in), .flush_in(flush_in), .valid_out(valid_out), .pc_out(pc_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .rd_write_out(rd_write_out),
    .alu_op_out(alu_op_out), .alu_sub_sra_out(alu_sub_sra_out),
    .alu_src1_out(alu_src1_out), .alu_src2_out(alu_src2_out),
    .imm_value_out(imm_value_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_width_out(mem_width_out),
    .mem_zero_ext_out(mem_zero_ext_out), .branch_out(branch_out),
    .branch_op_out(branch_op_out), .jump_out(jump_out), .jump_reg_out(jump_reg_out),
    .illegal_out(illegal_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        chk_alu;
    logic        rd_write;
    logic [3:0]  alu_op;
    logic        sub;
    logic [1:0]  src1;
    logic [1:0]  src2;
    logic        chk_imm;
    logic [31:0] imm;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  width;
    logic        zext;
    logic        branch;
    logic [2:0]  bop;
    logic        jump;
    logic        jump_reg;
    logic        illegal;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic chk_alu, input logic rdw, input logic [3:0] op,
                              input logic sub, input logic [1:0] s1, input logic [1:0] s2,
                              input logic chk_imm, input logic [31:0] imm,
                              input logic mr, input logic mw, input logic [1:0] w,
                              input logic z, input logic br, input logic [2:0] bop,
                              input logic j, input logic jr, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.chk_alu = chk_alu; v.rd_write = rdw; v.alu_op = op;
    v.sub = sub; v.src1 = s1; v.src2 = s2; v.chk_imm = chk_imm; v.imm = imm;
    v.mem_read = mr; v.mem_write = mw; v.width = w; v.zext = z; v.branch = br;
    v.bop = bop; v.jump = j; v.jump_reg = jr; v.illegal = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs mid-cycle, clock once, sample 1ns after the edge.
  task automatic step(input logic rst, input logic vld, input logic [31:0] instr,
                      input logic [31:0] pc, input logic stall, input logic flush);
    @(negedge clk);
    reset = rst; valid_in = vld; instr_in = instr; pc_in = pc;
    stall_in = stall; flush_in = flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            instr         pc          ca rw op    sb s1 s2 ci imm           mr mw w  z  br bop   j  jr il
    vecs[0]  = mk(32'hFFF08293, 32'h0000_0010, 1, 1, 4'h0, 0, 0, 1, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // ADDI x5,x1,-1
    vecs[1]  = mk(32'h0020A1B3, 32'h0000_0014, 1, 1, 4'h6, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // SLT
    vecs[2]  = mk(32'h0020C463, 32'h0000_0040, 1, 0, 4'h6, 1, 0, 0, 1, 32'h8,        0, 0, 0, 0, 1, 3'd4, 0, 0, 0); // BLT +8
    vecs[3]  = mk(32'h008000EF, 32'h0000_0100, 1, 1, 4'h0, 0, 1, 2, 1, 32'h8,        0, 0, 0, 0, 0, 3'd0, 1, 0, 0); // JAL x1,+8
    vecs[4]  = mk(32'h00412303, 32'h0000_0104, 1, 1, 4'h0, 0, 0, 1, 1, 32'h4,        1, 0, 2, 0, 0, 3'd0, 0, 0, 0); // LW x6,4(x2)
    vecs[5]  = mk(32'hFFF14303, 32'h0000_0108, 1, 1, 4'h0, 0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 3'd0, 0, 0, 0); // LBU x6,-1(x2)
    vecs[6]  = mk(32'h0020A423, 32'h0000_010C, 1, 0, 4'h0, 0, 0, 1, 1, 32'h8,        0, 1, 2, 0, 0, 3'd0, 0, 0, 0); // SW x2,8(x1)
    vecs[7]  = mk(32'h123453B7, 32'h0000_0110, 1, 1, 4'h0, 0, 2, 1, 1, 32'h12345000, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // LUI
    vecs[8]  = mk(32'h402081B3, 32'h0000_0114, 1, 1, 4'h0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // SUB
    vecs[9]  = mk(32'h0020818B, 32'h0000_0118, 1, 1, 4'h8, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // FXMUL
    vecs[10] = mk(32'h00000013, 32'h0000_011C, 1, 0, 4'h0, 0, 0, 1, 1, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // NOP, rd=x0
    vecs[11] = mk(32'h4030D093, 32'h0000_0120, 1, 1, 4'h5, 1, 0, 1, 1, 32'h403,      0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // SRAI x1,x1,3
    vecs[12] = mk(32'h00000000, 32'h0000_0124, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 1); // bits[1:0]=00
    vecs[13] = mk(32'h02109093, 32'h0000_0128, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 1); // SLLI, instr[25]=1
    vecs[14] = mk(32'h00000073, 32'h0000_012C, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3'd0, 0, 0, 1); // ECALL
    vecs[15] = mk(32'h004100E7, 32'h0000_0130, 1, 1, 4'h0, 0, 1, 2, 1, 32'h4,        0, 0, 0, 0, 0, 3'd0, 1, 1, 0); // JALR x1,4(x2)
    vecs[16] = mk(32'hFFFFF297, 32'h0000_0134, 1, 1, 4'h0, 0, 1, 1, 1, 32'hFFFFF000, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0); // AUIPC

    // Reset with junk on the inputs.
    step(1, 1, 32'hFFF08293, 32'h1234_5678, 0, 0);
    step(1, 1, 32'h0020C463, 32'h1234_5678, 1, 1);
    chk("rst_pc", pc_out, RST_PC);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_rd_write", 32'(rd_write_out), 32'd0);
    chk("rst_imm", imm_value_out, 32'd0);
    chk("rst_branch", 32'(branch_out), 32'd0);
    chk("rst_illegal", 32'(illegal_out), 32'd0);

    step(0, 0, 32'hFFF08293, 32'h0000_0200, 0, 0);
    chk("idle_valid", 32'(valid_out), 32'd0);
    chk("idle_rd_write", 32'(rd_write_out), 32'd0);
    chk("idle_pc", pc_out, 32'h0000_0200);

    for (int i = 0; i < NV; i++) begin
      step(0, 1, vecs[i].instr, vecs[i].pc, 0, 0);
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'd1);
      chk($sformatf("v%0d_pc", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d_rs1", i), 32'(rs1_out), 32'(vecs[i].instr[19:15]));
      chk($sformatf("v%0d_rs2", i), 32'(rs2_out), 32'(vecs[i].instr[24:20]));
      chk($sformatf("v%0d_rd", i), 32'(rd_out), 32'(vecs[i].instr[11:7]));
      chk($sformatf("v%0d_rd_write", i), 32'(rd_write_out), 32'(vecs[i].rd_write));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read_out), 32'(vecs[i].mem_read));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write_out), 32'(vecs[i].mem_write));
      chk($sformatf("v%0d_branch", i), 32'(branch_out), 32'(vecs[i].branch));
      chk($sformatf("v%0d_jump", i), 32'(jump_out), 32'(vecs[i].jump));
      chk($sformatf("v%0d_jump_reg", i), 32'(jump_reg_out), 32'(vecs[i].jump_reg));
      chk($sformatf("v%0d_illegal", i), 32'(illegal_out), 32'(vecs[i].illegal));
      if (vecs[i].chk_alu) begin
        chk($sformatf("v%0d_alu_op", i), 32'(alu_op_out), 32'(vecs[i].alu_op));
        chk($sformatf("v%0d_sub_sra", i), 32'(alu_sub_sra_out), 32'(vecs[i].sub));
        chk($sformatf("v%0d_src1", i), 32'(alu_src1_out), 32'(vecs[i].src1));
        chk($sformatf("v%0d_src2", i), 32'(alu_src2_out), 32'(vecs[i].src2));
      end
      if (vecs[i].chk_imm)
        chk($sformatf("v%0d_imm", i), imm_value_out, vecs[i].imm);
      if (vecs[i].mem_read || vecs[i].mem_write)
        chk($sformatf("v%0d_mem_width", i), 32'(mem_width_out), 32'(vecs[i].width));
      if (vecs[i].mem_read)
        chk($sformatf("v%0d_zero_ext", i), 32'(mem_zero_ext_out), 32'(vecs[i].zext));
      if (vecs[i].branch)
        chk($sformatf("v%0d_branch_op", i), 32'(branch_op_out), 32'(vecs[i].bop));
    end

    // Stall for two cycles while the input changes: outputs stay on the LW.
    step(0, 1, 32'h00412303, 32'h0000_0300, 0, 0);
    for (int c = 0; c < 2; c++) begin
      step(0, 1, 32'h0020A423 + 32'(c), 32'h0000_0400, 1, 0);
      chk($sformatf("stall%0d_pc", c), pc_out, 32'h0000_0300);
      chk($sformatf("stall%0d_rd", c), 32'(rd_out), 32'd6);
      chk($sformatf("stall%0d_imm", c), imm_value_out, 32'h4);
      chk($sformatf("stall%0d_mem_read", c), 32'(mem_read_out), 32'd1);
      chk($sformatf("stall%0d_mem_write", c), 32'(mem_write_out), 32'd0);
      chk($sformatf("stall%0d_valid", c), 32'(valid_out), 32'd1);
    end
    // Stall released: the SW now presented is taken.
    step(0, 1, 32'h0020A423, 32'h0000_0404, 0, 0);
    chk("unstall_mem_write", 32'(mem_write_out), 32'd1);
    chk("unstall_pc", pc_out, 32'h0000_0404);

    // Flush together with stall kills the held instruction.
    step(0, 1, 32'h008000EF, 32'h0000_0500, 0, 0);
    chk("pre_flush_jump", 32'(jump_out), 32'd1);
    step(0, 1, 32'h00412303, 32'h0000_0600, 1, 1);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_rd_write", 32'(rd_write_out), 32'd0);
    chk("flush_jump", 32'(jump_out), 32'd0);
    chk("flush_mem_read", 32'(mem_read_out), 32'd0);

    // Bubble after a live instruction.
    step(0, 1, 32'hFFF08293, 32'h0000_0700, 0, 0);
    step(0, 0, 32'h00412303, 32'h0000_0704, 0, 0);
    chk("bubble_valid", 32'(valid_out), 32'd0);
    chk("bubble_rd_write", 32'(rd_write_out), 32'd0);
    chk("bubble_mem_read", 32'(mem_read_out), 32'd0);

    // Reset asserted mid-stall.
    step(0, 1, 32'hFFF08293, 32'h0000_0800, 0, 0);
    step(0, 1, 32'h00412303, 32'h0000_0804, 1, 0);
    step(1, 1, 32'h00412303, 32'h0000_0804, 1, 0);
    chk("rst_stall_pc", pc_out, RST_PC);
    chk("rst_stall_valid", 32'(valid_out), 32'd0);
    chk("rst_stall_imm", imm_value_out, 32'd0);
    chk("rst_stall_rd_write", 32'(rd_write_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
